// File: rtl/wallace_mul_pipe.sv
// Pipelined N x N Wallace-tree multiplier with per-operation signed/unsigned mode
// (Baugh-Wooley) and valid/ready handshakes on both sides.
module wallace_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int MAXH = WIDTH + 2;

  typedef struct packed {
    logic [PW-1:0] sum;
    logic [PW-1:0] carry;
  } rows_t;

  // Upper bound on Wallace layers for the tallest column; extra layers are skipped.
  function automatic int wallace_layers(input int h0);
    int h;
    int n;
    h = h0;
    n = 0;
    while (h > 2) begin
      h = 2 * (h / 3) + h % 3;
      n++;
    end
    return n + 2;
  endfunction

  localparam int LAYERS = wallace_layers(WIDTH);

  // Column-wise bit matrix reduced layer by layer; column PW is a sink for carries
  // past the product width, which wrap out modulo 2^PW.
  function automatic rows_t wallace_reduce(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
    logic [MAXH-1:0] cur [PW+1];
    logic [MAXH-1:0] nxt [PW+1];
    int              h   [PW+1];
    int              nh  [PW+1];
    int              k;
    int              maxh;
    logic            inv;
    logic            x, y, z;
    rows_t           r;

    for (int c = 0; c <= PW; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end

    // Baugh-Wooley: invert cross terms touching exactly one sign bit, add 2^W + 2^(2W-1).
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        inv = sgn & ((i == WIDTH - 1) != (j == WIDTH - 1));
        cur[i+j][h[i+j]] = (a[j] & b[i]) ^ inv;
        h[i+j]++;
      end
    end
    cur[WIDTH][h[WIDTH]] = sgn;
    h[WIDTH]++;
    cur[PW-1][h[PW-1]] = sgn;
    h[PW-1]++;

    for (int l = 0; l < LAYERS; l++) begin
      maxh = 0;
      for (int c = 0; c < PW; c++) begin
        if (h[c] > maxh) maxh = h[c];
      end
      if (maxh > 2) begin
        for (int c = 0; c <= PW; c++) begin
          nxt[c] = '0;
          nh[c]  = 0;
        end
        for (int c = 0; c < PW; c++) begin
          k = 0;
          for (int g = 0; g < MAXH / 3 + 1; g++) begin
            if (h[c] - k >= 3) begin
              x = cur[c][k];
              y = cur[c][k+1];
              z = cur[c][k+2];
              nxt[c][nh[c]] = x ^ y ^ z;
              nh[c]++;
              nxt[c+1][nh[c+1]] = (x & y) | (x & z) | (y & z);
              nh[c+1]++;
              k += 3;
            end
          end
          if (h[c] - k == 2) begin
            x = cur[c][k];
            y = cur[c][k+1];
            nxt[c][nh[c]] = x ^ y;
            nh[c]++;
            nxt[c+1][nh[c+1]] = x & y;
            nh[c+1]++;
          end else if (h[c] - k == 1) begin
            nxt[c][nh[c]] = cur[c][k];
            nh[c]++;
          end
        end
        cur = nxt;
        h   = nh;
      end
    end

    for (int c = 0; c < PW; c++) begin
      r.sum[c]   = cur[c][0];
      r.carry[c] = cur[c][1];
    end
    return r;
  endfunction

  logic               v1_q, v2_q, v3_q;
  logic [WIDTH-1:0]   a1_q, b1_q;
  logic               s1_q;
  logic [TAG_W-1:0]   tag1_q, tag2_q, tag3_q;
  logic [PW-1:0]      sum2_q, carry2_q, prod3_q;
  rows_t              rows_d;
  logic [PW-1:0]      prod_d;
  logic               adv;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;
  assign rows_d   = wallace_reduce(a1_q, b1_q, s1_q);
  assign prod_d   = sum2_q + carry2_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      prod3_q <= '0;
      tag3_q  <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (v2_q) begin
        prod3_q <= prod_d;
        tag3_q  <= tag2_q;
      end
    end
  end

  // NOTE: inner datapath registers have no reset; the valid bits alone decide
  // whether their contents are meaningful.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      a1_q   <= in_a;
      b1_q   <= in_b;
      s1_q   <= in_signed;
      tag1_q <= in_tag;
    end
    if (adv && v1_q) begin
      sum2_q   <= rows_d.sum;
      carry2_q <= rows_d.carry;
      tag2_q   <= tag1_q;
    end
  end

  assign out_valid = v3_q;
  assign out_prod  = prod3_q;
  assign out_tag   = tag3_q;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Directed self-checking bench for wallace_mul_pipe at WIDTH=8, TAG_W=4.
module tb_wallace_mul_pipe;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [WIDTH-1:0]    in_a = '0;
  logic [WIDTH-1:0]    in_b = '0;
  logic                in_signed = 1'b0;
  logic [TAG_W-1:0]    in_tag = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [2*WIDTH-1:0]  out_prod;
  logic [TAG_W-1:0]    out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_mul_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_tag   (out_tag)
  );

  // Entries 0..3: signed corner cases (tags 4..7); 4..11: alternating stream (tags 0..7).
  logic [7:0]  t_a [12] = '{8'h80, 8'h80, 8'hFF, 8'h00,
                            8'h03, 8'h10, 8'h7F, 8'hFF, 8'hFE, 8'h80, 8'h81, 8'hAB};
  logic [7:0]  t_b [12] = '{8'h80, 8'h7F, 8'h01, 8'h80,
                            8'hFD, 8'h10, 8'h7F, 8'h02, 8'hFE, 8'h80, 8'h02, 8'hCD};
  logic        t_s [12] = '{1'b1, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [3:0]  t_t [12] = '{4'd4, 4'd5, 4'd6, 4'd7,
                            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
  logic [15:0] t_p [12] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h0000,
                            16'hFFF7, 16'h0100, 16'h3F01, 16'h01FE,
                            16'h0004, 16'h4000, 16'hFF02, 16'h88EF};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [3:0] t);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = t;
  endtask

  // One op per cycle from an empty pipe; each result must appear exactly 3 cycles later.
  task automatic run_stream(input int first, input int n);
    for (int t = 0; t < n + 2; t++) begin
      if (t < n) drive(1'b1, t_a[first+t], t_b[first+t], t_s[first+t], t_t[first+t]);
      else       drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
      tick();
      if (t < 2) begin
        check("stream_lead_idle", out_valid, 1'b0);
      end else begin
        check("stream_valid", out_valid, 1'b1);
        check("stream_prod", out_prod, t_p[first+t-2]);
        check("stream_tag", out_tag, t_t[first+t-2]);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    tick();
    check("stream_drained", out_valid, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_prod", out_prod, 16'h0000);
    check("rst_out_tag", out_tag, 4'h0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);

    // Single unsigned op, latency 3
    out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 4'd3);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    check("lat_edge1", out_valid, 1'b0);
    tick();
    check("lat_edge2", out_valid, 1'b0);
    tick();
    check("lat_edge3_valid", out_valid, 1'b1);
    check("lat_prod", out_prod, 16'hFE01);
    check("lat_tag", out_tag, 4'd3);
    tick();
    check("bubble_not_emitted", out_valid, 1'b0);

    // Signed corner cases, then alternating mixed-mode stream
    run_stream(0, 4);
    run_stream(4, 8);

    // Backpressure: A,B,C fill the pipe, D waits at the input during the stall
    drive(1'b1, 8'h12, 8'h34, 1'b0, 4'd9);
    tick();
    drive(1'b1, 8'hF0, 8'h10, 1'b1, 4'd10);
    tick();
    drive(1'b1, 8'h0F, 8'h0F, 1'b0, 4'd11);
    tick();
    drive(1'b1, 8'h7F, 8'h80, 1'b1, 4'd12);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_head_prod", out_prod, 16'h03A8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_ready", in_ready, 1'b0);
      check("bp_hold_prod", out_prod, 16'h03A8);
      check("bp_hold_tag", out_tag, 4'd9);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    check("bp_b_prod", out_prod, 16'hFF00);
    check("bp_b_tag", out_tag, 4'd10);
    tick();
    check("bp_c_prod", out_prod, 16'h00E1);
    check("bp_c_tag", out_tag, 4'd11);
    tick();
    check("bp_d_valid", out_valid, 1'b1);
    check("bp_d_prod", out_prod, 16'hC080);
    check("bp_d_tag", out_tag, 4'd12);
    tick();
    check("bp_no_dup", out_valid, 1'b0);

    // Reset with three ops in flight (head stalled at the output)
    out_ready = 1'b0;
    drive(1'b1, 8'h55, 8'h33, 1'b0, 4'd13);
    tick();
    drive(1'b1, 8'h55, 8'h33, 1'b1, 4'd14);
    tick();
    drive(1'b1, 8'hAA, 8'h33, 1'b0, 4'd15);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 4'h0);
    check("mid_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_prod", out_prod, 16'h0000);
    check("mid_rst_tag", out_tag, 4'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("mid_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_discarded", out_valid, 1'b0);
    end

    // Recovery after reset
    run_stream(11, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
